// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - start/stop/pause controlled up/down counter with terminal clamp and wrap flag
module count_sequencer #(
    parameter int BITS   = 16,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              mode,
    input  logic [BITS-1:0]   load_val,
    input  logic [BITS-1:0]   term_val,
    input  logic [STEP_W-1:0] step,
    output logic [BITS-1:0]   count,
    output logic              busy,
    output logic              done,
    output logic              wrap,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t            state_q;
    logic              mode_q;
    logic [BITS-1:0]   term_q;
    logic [STEP_W-1:0] step_q;

    logic [BITS-1:0] step_ext;
    logic [BITS:0]   sum_up;
    logic [BITS:0]   diff_dn;
    logic            at_term_dn;
    logic            at_term_up;

    assign step_ext   = BITS'(step_q);
    assign sum_up     = {1'b0, count} + {1'b0, step_ext};
    assign diff_dn    = {1'b0, count} - {1'b0, step_ext};
    // Clamp to term when the next step would reach or pass it
    assign at_term_dn = (count >= term_q) && ((count - term_q) <= step_ext);
    assign at_term_up = (count <= term_q) && ((term_q - count) <= step_ext);

    assign state = state_q;
    assign busy  = (state_q == RUN) || (state_q == HOLD);
    assign done  = (state_q == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count   <= '0;
            mode_q  <= 1'b0;
            term_q  <= '0;
            step_q  <= '0;
            wrap    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        count   <= load_val;
                        mode_q  <= mode;
                        term_q  <= term_val;
                        step_q  <= (step == '0) ? STEP_W'(1) : step;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q <= IDLE;
                    end else if (pause) begin
                        state_q <= HOLD;
                    end else if (mode_q ? at_term_up : at_term_dn) begin
                        count   <= term_q;
                        state_q <= DONE;
                    end else if (mode_q) begin
                        count <= sum_up[BITS-1:0];
                        wrap  <= sum_up[BITS];
                    end else begin
                        count <= diff_dn[BITS-1:0];
                        wrap  <= diff_dn[BITS];
                    end
                end
                HOLD: begin
                    if (stop) begin
                        state_q <= IDLE;
                    end else if (!pause) begin
                        state_q <= RUN;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - directed self-checking bench for count_sequencer
module tb_count_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic        pause;
    logic        mode;
    logic [15:0] load_val;
    logic [15:0] term_val;
    logic [7:0]  step;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic        wrap;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    count_sequencer #(.BITS(16), .STEP_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .mode     (mode),
        .load_val (load_val),
        .term_val (term_val),
        .step     (step),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input logic m, input logic [15:0] ld, input logic [15:0] tm, input logic [7:0] st);
        mode     = m;
        load_val = ld;
        term_val = tm;
        step     = st;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] c, input logic [1:0] s,
                              input logic d, input logic w);
        check({tag, "_count"}, 32'(count), 32'(c));
        check({tag, "_state"}, 32'(state), 32'(s));
        check({tag, "_done"},  32'(done),  32'(d));
        check({tag, "_wrap"},  32'(wrap),  32'(w));
        check({tag, "_busy"},  32'(busy),  32'((s == 2'b01) || (s == 2'b10)));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        mode = 1'b0; load_val = '0; term_val = '0; step = '0;
        tick();
        expect_out("reset", 16'd0, 2'b00, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        expect_out("idle", 16'd0, 2'b00, 1'b0, 1'b0);

        // Down 100 -> 0 by 10; scramble inputs mid-run to prove they are latched
        begin_run(1'b0, 16'd100, 16'd0, 8'd10);
        expect_out("dn_load", 16'd100, 2'b01, 1'b0, 1'b0);
        mode = 1'b1; load_val = 16'd7; term_val = 16'd999; step = 8'd1;
        for (int v = 90; v >= 10; v -= 10) begin
            tick();
            expect_out("dn_step", 16'(v), 2'b01, 1'b0, 1'b0);
        end
        tick();
        expect_out("dn_done", 16'd0, 2'b11, 1'b1, 1'b0);
        tick();
        expect_out("dn_idle", 16'd0, 2'b00, 1'b0, 1'b0);

        // Down with borrow across zero
        begin_run(1'b0, 16'd5, 16'd65530, 8'd10);
        expect_out("wr_load", 16'd5, 2'b01, 1'b0, 1'b0);
        tick();
        expect_out("wr_wrap", 16'd65531, 2'b01, 1'b0, 1'b1);
        tick();
        expect_out("wr_done", 16'd65530, 2'b11, 1'b1, 1'b0);
        tick();
        expect_out("wr_idle", 16'd65530, 2'b00, 1'b0, 1'b0);

        // Up with clamp to term
        begin_run(1'b1, 16'd0, 16'd25, 8'd10);
        tick(); expect_out("up_10", 16'd10, 2'b01, 1'b0, 1'b0);
        tick(); expect_out("up_20", 16'd20, 2'b01, 1'b0, 1'b0);
        tick(); expect_out("up_25", 16'd25, 2'b11, 1'b1, 1'b0);
        tick(); expect_out("up_idle", 16'd25, 2'b00, 1'b0, 1'b0);

        // Step of zero behaves as one
        begin_run(1'b1, 16'd0, 16'd3, 8'd0);
        tick(); expect_out("s0_1", 16'd1, 2'b01, 1'b0, 1'b0);
        tick(); expect_out("s0_2", 16'd2, 2'b01, 1'b0, 1'b0);
        tick(); expect_out("s0_3", 16'd3, 2'b11, 1'b1, 1'b0);
        tick();

        // Up carry out of the top bit
        begin_run(1'b1, 16'd65530, 16'd20, 8'd10);
        tick(); expect_out("upw_wrap", 16'd4, 2'b01, 1'b0, 1'b1);
        tick(); expect_out("upw_14", 16'd14, 2'b01, 1'b0, 1'b0);
        tick(); expect_out("upw_done", 16'd20, 2'b11, 1'b1, 1'b0);
        tick();

        // load equal to term still passes through RUN
        begin_run(1'b0, 16'd7, 16'd7, 8'd3);
        expect_out("eq_run", 16'd7, 2'b01, 1'b0, 1'b0);
        tick(); expect_out("eq_done", 16'd7, 2'b11, 1'b1, 1'b0);
        tick(); expect_out("eq_idle", 16'd7, 2'b00, 1'b0, 1'b0);

        // Pause at 70 for three cycles, then stop while paused
        begin_run(1'b0, 16'd100, 16'd0, 8'd10);
        tick(); tick(); tick();
        expect_out("ps_70", 16'd70, 2'b01, 1'b0, 1'b0);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("ps_hold", 16'd70, 2'b10, 1'b0, 1'b0);
        end
        stop = 1'b1;
        tick();
        expect_out("ps_stop", 16'd70, 2'b00, 1'b0, 1'b0);
        stop = 1'b0; pause = 1'b0;
        tick();
        expect_out("ps_after", 16'd70, 2'b00, 1'b0, 1'b0);

        // Resume from HOLD takes an edge without updating
        begin_run(1'b0, 16'd100, 16'd0, 8'd10);
        pause = 1'b1;
        tick(); expect_out("rs_hold", 16'd100, 2'b10, 1'b0, 1'b0);
        pause = 1'b0;
        tick(); expect_out("rs_run", 16'd100, 2'b01, 1'b0, 1'b0);
        tick(); expect_out("rs_90", 16'd90, 2'b01, 1'b0, 1'b0);
        stop = 1'b1; pause = 1'b1;
        tick(); expect_out("rs_stop", 16'd90, 2'b00, 1'b0, 1'b0);
        stop = 1'b0; pause = 1'b0;

        // Asynchronous reset mid-run at 50
        begin_run(1'b0, 16'd100, 16'd0, 8'd10);
        for (int i = 0; i < 5; i++) tick();
        expect_out("ar_50", 16'd50, 2'b01, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1 expect_out("ar_async", 16'd0, 2'b00, 1'b0, 1'b0);
        #1 reset = 1'b0;
        tick();
        expect_out("ar_rel", 16'd0, 2'b00, 1'b0, 1'b0);
        begin_run(1'b0, 16'd100, 16'd0, 8'd10);
        expect_out("ar_reload", 16'd100, 2'b01, 1'b0, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // start+stop together in IDLE, start held through the run
        mode = 1'b1; load_val = 16'd0; term_val = 16'd3; step = 8'd1;
        start = 1'b1; stop = 1'b1;
        tick(); expect_out("ss_run", 16'd0, 2'b01, 1'b0, 1'b0);
        stop = 1'b0;
        load_val = 16'd40;
        tick(); expect_out("ss_1", 16'd1, 2'b01, 1'b0, 1'b0);
        tick(); expect_out("ss_2", 16'd2, 2'b01, 1'b0, 1'b0);
        tick(); expect_out("ss_done", 16'd3, 2'b11, 1'b1, 1'b0);
        tick(); expect_out("ss_idle", 16'd3, 2'b00, 1'b0, 1'b0);
        tick(); expect_out("ss_restart", 16'd40, 2'b01, 1'b0, 1'b0);
        start = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
